pipe_elastic_stage: RTL and testbench

//  Parametrised elastic register stage between CPU pipeline stages (fetch->decode, decode->execute, ...).

---
 rtl/pipe_elastic_stage.sv | 91 +++++++++
 tb/tb_pipe_elastic_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_elastic_stage.sv
// Elastic register stage between CPU pipeline stages: DEPTH-entry circular buffer
// with valid/ready handshake, back-pressure and synchronous flush. All outputs come from flops.
module pipe_elastic_stage #(
  parameter int unsigned W     = 96,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW-1:0] wp_nxt;
  logic [PW-1:0] rp_nxt;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Head entry is read straight from the storage flops; stable while stalled.
  assign out_data = mem[rp];

  // Pointer/count next-state; flush overrides any push or pop in the same cycle.
  always_comb begin
    wp_nxt    = wp;
    rp_nxt    = rp;
    count_nxt = count;
    if (flush) begin
      wp_nxt    = '0;
      rp_nxt    = '0;
      count_nxt = '0;
    end else begin
      if (push) begin
        wp_nxt = (wp == PW'(DEPTH - 1)) ? '0 : wp + PW'(1);
      end
      if (pop) begin
        rp_nxt = (rp == PW'(DEPTH - 1)) ? '0 : rp + PW'(1);
      end
      if (push && !pop) begin
        count_nxt = count + CW'(1);
      end else if (pop && !push) begin
        count_nxt = count - CW'(1);
      end
    end
  end

  // Status flags are registered from the next count so no in->out or ready->ready path exists.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      full      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      wp        <= wp_nxt;
      rp        <= rp_nxt;
      count     <= count_nxt;
      full      <= (count_nxt == CW'(DEPTH));
      in_ready  <= (count_nxt != CW'(DEPTH));
      out_valid <= (count_nxt != '0);
      if (push && !flush) begin
        mem[wp] <= in_data;
      end
    end
  end

  // Occupancy invariants.
  a_count_bound : assert property (@(posedge clk) disable iff (!reset) count <= CW'(DEPTH));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (!reset) !(pop && count == '0));

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Bench for pipe_elastic_stage: DEPTH=2 and DEPTH=3 instances driven in parallel,
// checked against queue-based models plus a directed vector table.
module tb_pipe_elastic_stage;

  localparam int unsigned W = 96;

  typedef struct {
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [63:0] pc;
    logic        e_ov;
    logic        e_ir;
    int          e_cnt;
    logic [63:0] e_pc;
  } vec_t;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] in_data;

  logic         ir2, ov2, full2;
  logic [W-1:0] od2;
  logic [1:0]   cnt2;
  logic         ir3, ov3, full3;
  logic [W-1:0] od3;
  logic [1:0]   cnt3;

  logic [W-1:0] q2[$];
  logic [W-1:0] q3[$];
  int pushes3;
  int pops3;
  int nchecks;
  int nerr;
  vec_t tv [20];

  pipe_elastic_stage #(.W(W), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .count(cnt2), .full(full2));

  pipe_elastic_stage #(.W(W), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir3),
    .in_data(in_data), .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
    .count(cnt3), .full(full3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pld(input logic [63:0] pc);
    return {32'h0000_0013, pc};
  endfunction

  function automatic vec_t mk(input logic fl, input logic iv, input logic ordy, input logic [63:0] pc,
                              input logic e_ov, input logic e_ir, input int e_cnt, input logic [63:0] e_pc);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ordy = ordy; v.pc = pc;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_cnt = e_cnt; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk_i(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_d(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare both instances against their occupancy models, away from the active edge.
  task automatic sample();
    @(negedge clk);
    chk_i("d2.out_valid", int'(ov2), int'(q2.size() != 0));
    chk_i("d2.in_ready", int'(ir2), int'(q2.size() < 2));
    chk_i("d2.count", int'(cnt2), q2.size());
    chk_i("d2.full", int'(full2), int'(q2.size() == 2));
    if (q2.size() != 0) chk_d("d2.out_data", od2, q2[0]);
    chk_i("d3.out_valid", int'(ov3), int'(q3.size() != 0));
    chk_i("d3.in_ready", int'(ir3), int'(q3.size() < 3));
    chk_i("d3.count", int'(cnt3), q3.size());
    chk_i("d3.full", int'(full3), int'(q3.size() == 3));
    if (q3.size() != 0) chk_d("d3.out_data", od3, q3[0]);
  endtask

  // Advance one clock and apply the handshake rules to the models.
  task automatic edge_step();
    logic p2, o2, p3, o3;
    @(posedge clk);
    if (!reset || flush) begin
      q2.delete();
      q3.delete();
    end else begin
      p2 = in_valid && (q2.size() < 2);
      o2 = out_ready && (q2.size() != 0);
      p3 = in_valid && (q3.size() < 3);
      o3 = out_ready && (q3.size() != 0);
      if (o2) void'(q2.pop_front());
      if (p2) q2.push_back(in_data);
      if (o3) begin void'(q3.pop_front()); pops3++; end
      if (p3) begin q3.push_back(in_data); pushes3++; end
    end
    #1;
  endtask

  task automatic cycle();
    sample();
    edge_step();
  endtask

  initial begin
    nchecks = 0; nerr = 0; pushes3 = 0; pops3 = 0;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_data = pld(64'hDEAD);

    tv[0]  = mk(0, 1, 1, 64'h1000, 0, 1, 0, 64'h0);
    tv[1]  = mk(0, 1, 1, 64'h1004, 1, 1, 1, 64'h1000);
    tv[2]  = mk(0, 1, 1, 64'h1008, 1, 1, 1, 64'h1004);
    tv[3]  = mk(0, 0, 1, 64'h0,    1, 1, 1, 64'h1008);
    tv[4]  = mk(0, 0, 1, 64'h0,    0, 1, 0, 64'h0);
    tv[5]  = mk(0, 1, 0, 64'hA,    0, 1, 0, 64'h0);
    tv[6]  = mk(0, 1, 0, 64'hB,    1, 1, 1, 64'hA);
    tv[7]  = mk(0, 1, 0, 64'hC,    1, 0, 2, 64'hA);
    tv[8]  = mk(0, 1, 0, 64'hC,    1, 0, 2, 64'hA);
    tv[9]  = mk(0, 1, 1, 64'hC,    1, 0, 2, 64'hA);
    tv[10] = mk(0, 1, 1, 64'hC,    1, 1, 1, 64'hB);
    tv[11] = mk(0, 0, 1, 64'h0,    1, 1, 1, 64'hC);
    tv[12] = mk(0, 0, 1, 64'h0,    0, 1, 0, 64'h0);
    tv[13] = mk(0, 1, 0, 64'hD,    0, 1, 0, 64'h0);
    tv[14] = mk(0, 1, 0, 64'hE,    1, 1, 1, 64'hD);
    tv[15] = mk(1, 1, 1, 64'hF,    1, 0, 2, 64'hD);
    tv[16] = mk(0, 0, 1, 64'h0,    0, 1, 0, 64'h0);
    tv[17] = mk(0, 1, 1, 64'h70,   0, 1, 0, 64'h0);
    tv[18] = mk(0, 0, 1, 64'h0,    1, 1, 1, 64'h70);
    tv[19] = mk(0, 0, 0, 64'h0,    0, 1, 0, 64'h0);

    // Reset held with in_valid high.
    repeat (3) cycle();
    sample();
    chk_i("rst.out_valid", int'(ov2), 0);
    chk_i("rst.in_ready", int'(ir2), 1);
    chk_i("rst.count", int'(cnt2), 0);
    chk_d("rst.out_data", od2, '0);
    chk_d("rst.out_data3", od3, '0);
    edge_step();
    reset = 1'b1;
    in_valid = 1'b0;

    // Directed table: streaming, back-pressure, flush.
    for (int k = 0; k < 20; k++) begin
      flush = tv[k].fl; in_valid = tv[k].iv; out_ready = tv[k].ordy; in_data = pld(tv[k].pc);
      sample();
      chk_i($sformatf("v%0d.out_valid", k), int'(ov2), int'(tv[k].e_ov));
      chk_i($sformatf("v%0d.in_ready", k), int'(ir2), int'(tv[k].e_ir));
      chk_i($sformatf("v%0d.count", k), int'(cnt2), tv[k].e_cnt);
      chk_i($sformatf("v%0d.full", k), int'(full2), int'(tv[k].e_cnt == 2));
      if (tv[k].e_ov) chk_d($sformatf("v%0d.out_data", k), od2, pld(tv[k].e_pc));
      edge_step();
    end
    flush = 1'b0;

    // Wrap on DEPTH=3: 10 pushes, 7 pops with random back-pressure.
    flush = 1'b1; in_valid = 1'b0; cycle(); flush = 1'b0;
    pushes3 = 0; pops3 = 0;
    begin : wrap_run
      int budget;
      budget = 0;
      while ((pushes3 < 10 || pops3 < 7) && budget < 200) begin
        in_valid  = (pushes3 < 10);
        out_ready = (pops3 < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
        in_data   = {$urandom, $urandom, $urandom};
        cycle();
        budget++;
      end
      chk_i("wrap.budget", int'(budget < 200), 1);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    sample();
    chk_i("wrap.count3", int'(cnt3), 3);
    edge_step();
    // Drain so the order of the wrapped entries is seen on the output.
    out_ready = 1'b1;
    repeat (4) cycle();

    // Random traffic with occasional flushes.
    for (int n = 0; n < 400; n++) begin
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom, $urandom};
      cycle();
    end
    flush = 1'b0;

    // Async reset mid-stream with two entries held.
    flush = 1'b1; cycle(); flush = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    in_data = pld(64'h2000); cycle();
    in_data = pld(64'h2004); cycle();
    in_valid = 1'b0;
    sample();
    chk_i("arst.pre_count", int'(cnt2), 2);
    #2 reset = 1'b0;
    #1;
    chk_i("arst.out_valid", int'(ov2), 0);
    chk_i("arst.count", int'(cnt2), 0);
    chk_i("arst.in_ready", int'(ir2), 1);
    chk_i("arst.full", int'(full2), 0);
    chk_d("arst.out_data", od2, '0);
    q2.delete(); q3.delete();
    edge_step();
    reset = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = pld(64'h1000); cycle();
    in_valid = 1'b0;
    sample();
    chk_i("arst.after_ov", int'(ov2), 1);
    chk_d("arst.after_data", od2, pld(64'h1000));
    edge_step();
    repeat (2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
